// File: rtl/pipelined_memory.sv
// Purpose : word memory with byte-enabled always-accepting writes and a valid/ready read port
// Latency : read accepted at edge E0 presents rd_resp_valid after edge E0+READ_LATENCY-1 (fall-through buffer)
// Backpres: credit limited to READ_LATENCY+1 outstanding reads; a stalled response is held in the buffer
//
// Ports:
//   clock, reset_n                        rising-edge clock, async active-low reset
//   wr_en/wr_addr/wr_data/wr_byte_en      write port, never stalls
//   rd_req_valid/rd_req_ready/rd_req_addr read request handshake
//   rd_resp_valid/rd_resp_ready/rd_resp_data  in-order read responses
//   stat_reads/stat_writes/stat_stalls    only when PIPELINED_MEMORY_STATS_EN is defined
//
// Parameters: ADDR_WIDTH, DATA_WIDTH (multiple of 8), READ_LATENCY (1..4),
//             RDW_MODE (0 = same-edge read sees old word, 1 = sees byte-merged new word)

// Small fall-through FIFO. No full flag: the caller guarantees it never pushes when full.
module pipelined_memory_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign push    = in_vld;
    assign out_vld = (count != '0);
    assign pop     = out_vld && out_rdy;
    assign out_dat = store[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            store[wr_ptr] <= in_dat;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module pipelined_memory #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    parameter int RDW_MODE     = 0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_byte_en,
    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    input  logic [ADDR_WIDTH-1:0]   rd_req_addr,
    output logic                    rd_resp_valid,
    input  logic                    rd_resp_ready,
`ifdef PIPELINED_MEMORY_STATS_EN
    output logic [31:0]             stat_reads,
    output logic [31:0]             stat_writes,
    output logic [31:0]             stat_stalls,
`endif
    output logic [DATA_WIDTH-1:0]   rd_resp_data
);
    localparam int BE_W    = DATA_WIDTH / 8;
    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam int CREDITS = READ_LATENCY + 1;
    localparam int OW      = $clog2(CREDITS + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  rd_accept;
    logic                  rd_consume;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  pipe_vld [READ_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_dat [READ_LATENCY];
    logic                  tail_vld;
    logic [DATA_WIDTH-1:0] tail_dat;

    logic                  fifo_in_vld;
    logic                  fifo_out_vld;
    logic [DATA_WIDTH-1:0] fifo_out_dat;

    logic [OW-1:0]         outstanding;

    // ---------------- storage ----------------
    always_ff @(posedge clock) begin
        for (int i = 0; i < BE_W; i++) begin
            if (wr_en && wr_byte_en[i]) begin
                mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign rd_accept = rd_req_valid && rd_req_ready;
    assign old_word  = mem[rd_req_addr];

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (wr_byte_en[i]) begin
                merged_word[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    // Same-edge collision: in mode 1 the write is forwarded into the sampled word.
    always_comb begin
        rd_word = old_word;
        if (RDW_MODE == 1 && wr_en && (wr_addr == rd_req_addr)) begin
            rd_word = merged_word;
        end
    end

    // ---------------- fixed-latency read pipeline ----------------
    // Stage 0 captures the array at the accept edge; the pipe never stalls because
    // the credit limit guarantees room in the response buffer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_vld[k] <= 1'b0;
                pipe_dat[k] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_accept;
            pipe_dat[0] <= rd_word;
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_dat[k] <= pipe_dat[k-1];
            end
        end
    end

    assign tail_vld = pipe_vld[READ_LATENCY-1];
    assign tail_dat = pipe_dat[READ_LATENCY-1];

    // ---------------- response buffer ----------------
    // The pipe tail bypasses the buffer only when the buffer is empty and the
    // consumer takes it this edge; otherwise it is queued behind older responses.
    assign fifo_in_vld = tail_vld && !(!fifo_out_vld && rd_resp_ready);

    pipelined_memory_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (CREDITS)
    ) u_resp_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .in_vld  (fifo_in_vld),
        .in_dat  (tail_dat),
        .out_vld (fifo_out_vld),
        .out_rdy (rd_resp_ready),
        .out_dat (fifo_out_dat)
    );

    assign rd_resp_valid = fifo_out_vld || tail_vld;
    assign rd_resp_data  = fifo_out_vld ? fifo_out_dat :
                           tail_vld     ? tail_dat     : '0;
    assign rd_consume    = rd_resp_valid && rd_resp_ready;

    // ---------------- credits ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else begin
            case ({rd_accept, rd_consume})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Registered-state only: no path from rd_req_valid or rd_resp_ready.
    assign rd_req_ready = (outstanding < OW'(CREDITS));

`ifdef PIPELINED_MEMORY_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_stalls <= '0;
        end else begin
            if (rd_accept) begin
                stat_reads <= stat_reads + 32'd1;
            end
            if (wr_en) begin
                stat_writes <= stat_writes + 32'd1;
            end
            if (rd_req_valid && !rd_req_ready) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end
`endif
endmodule
